// File: rtl/msdap_ctrl_if.sv
// Bundles the MSDAP sequencer's request, S2P, ALU and memory-write signals.
// master = sequencer side (drives strobes and ALU launch), slave = datapath/environment side.
// Widths follow ADDR_W; data words are fixed at 16 bits.
interface msdap_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic              flush;
  logic              s2p_ready;
  logic [15:0]       ParallelL;
  logic [15:0]       ParallelR;
  logic              alu_done;
  logic              rj_we;
  logic              coeff_we;
  logic              x_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data_l;
  logic [15:0]       wr_data_r;
  logic              alu_start;
  logic [ADDR_W-1:0] alu_xptr;
  logic [2:0]        state;
  logic              sleep_flag;
  logic              overrun;

  modport master (
    input  start, flush, s2p_ready, ParallelL, ParallelR, alu_done,
    output rj_we, coeff_we, x_we, wr_addr, wr_data_l, wr_data_r,
           alu_start, alu_xptr, state, sleep_flag, overrun
  );

  modport slave (
    output start, flush, s2p_ready, ParallelL, ParallelR, alu_done,
    input  rj_we, coeff_we, x_we, wr_addr, wr_data_l, wr_data_r,
           alu_start, alu_xptr, state, sleep_flag, overrun
  );
endinterface

// File: rtl/msdap_ctrl.sv
// MSDAP main sequencer: steers S2P words into Rj/coeff/X memories, launches the ALU per frame.
// Latency: one SCLK from s2p_ready to write strobe/address/data and alu_start (all registered).
// No backpressure: frames arriving while the ALU is busy are dropped and flagged in sticky overrun.
module msdap_ctrl #(
  parameter int RJ_COUNT    = 16,
  parameter int COEFF_COUNT = 512,
  parameter int X_DEPTH     = 256,
  parameter int SLEEP_ZEROS = 800,
  parameter int ADDR_W      = 9
) (
  input logic         SCLK,
  input logic         clear,
  msdap_ctrl_if.master bus
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CLEAR_MEM  = 3'd1;
  localparam logic [2:0] READ_RJ    = 3'd2;
  localparam logic [2:0] READ_COEFF = 3'd3;
  localparam logic [2:0] WAIT_INPUT = 3'd4;
  localparam logic [2:0] WORKING    = 3'd5;
  localparam logic [2:0] SLEEP      = 3'd6;

  localparam int ZC_W = $clog2(SLEEP_ZEROS + 1);
  localparam logic [ZC_W-1:0]   ZC_MAX  = ZC_W'(SLEEP_ZEROS);
  localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(X_DEPTH - 1);
  localparam logic [ADDR_W-1:0] RJ_LAST = ADDR_W'(RJ_COUNT - 1);
  localparam logic [ADDR_W-1:0] CF_LAST = ADDR_W'(COEFF_COUNT - 1);

  logic [2:0]        ret_tgt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] x_ptr;
  logic [ZC_W-1:0]   zero_cnt;

  logic              frame_zero;
  logic [ZC_W-1:0]   zc_next;
  logic [ADDR_W-1:0] x_ptr_next;

  // Zero-run count and circular X pointer as they would be after accepting the current frame.
  always_comb begin
    frame_zero = (bus.ParallelL == 16'd0) && (bus.ParallelR == 16'd0);
    zc_next    = '0;
    if (frame_zero) begin
      zc_next = (zero_cnt == ZC_MAX) ? zero_cnt : zero_cnt + 1'b1;
    end
    x_ptr_next = (x_ptr == X_LAST) ? '0 : x_ptr + 1'b1;
  end

  // Sequencer: state, counters and all registered outputs. Strobes default low every cycle.
  always_ff @(posedge SCLK or negedge clear) begin
    if (!clear) begin
      bus.state      <= IDLE;
      ret_tgt        <= IDLE;
      cnt            <= '0;
      x_ptr          <= '0;
      zero_cnt       <= '0;
      bus.rj_we      <= 1'b0;
      bus.coeff_we   <= 1'b0;
      bus.x_we       <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data_l  <= '0;
      bus.wr_data_r  <= '0;
      bus.alu_start  <= 1'b0;
      bus.alu_xptr   <= '0;
      bus.sleep_flag <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.rj_we     <= 1'b0;
      bus.coeff_we  <= 1'b0;
      bus.x_we      <= 1'b0;
      bus.alu_start <= 1'b0;

      if (bus.flush && (bus.state == WAIT_INPUT || bus.state == WORKING || bus.state == SLEEP)) begin
        // Flush wins over any frame or alu_done this cycle; the clear's first write goes out now.
        bus.state      <= CLEAR_MEM;
        ret_tgt        <= WAIT_INPUT;
        bus.x_we       <= 1'b1;
        bus.wr_addr    <= '0;
        bus.wr_data_l  <= '0;
        bus.wr_data_r  <= '0;
        cnt            <= ADDR_W'(1);
        x_ptr          <= '0;
        zero_cnt       <= '0;
        bus.sleep_flag <= 1'b0;
      end else begin
        case (bus.state)
          IDLE: begin
            if (bus.start) begin
              bus.state     <= CLEAR_MEM;
              ret_tgt       <= READ_RJ;
              bus.x_we      <= 1'b1;
              bus.wr_addr   <= '0;
              bus.wr_data_l <= '0;
              bus.wr_data_r <= '0;
              cnt           <= ADDR_W'(1);
              x_ptr         <= '0;
              zero_cnt      <= '0;
            end
          end

          CLEAR_MEM: begin
            bus.x_we      <= 1'b1;
            bus.wr_addr   <= cnt;
            bus.wr_data_l <= '0;
            bus.wr_data_r <= '0;
            if (cnt == X_LAST) begin
              cnt       <= '0;
              bus.state <= ret_tgt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          READ_RJ, READ_COEFF: begin
            if (bus.s2p_ready) begin
              bus.rj_we     <= (bus.state == READ_RJ);
              bus.coeff_we  <= (bus.state == READ_COEFF);
              bus.wr_addr   <= cnt;
              bus.wr_data_l <= bus.ParallelL;
              bus.wr_data_r <= bus.ParallelR;
              if (bus.state == READ_RJ && cnt == RJ_LAST) begin
                cnt       <= '0;
                bus.state <= READ_COEFF;
              end else if (bus.state == READ_COEFF && cnt == CF_LAST) begin
                cnt       <= '0;
                bus.state <= WAIT_INPUT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end

          WAIT_INPUT: begin
            if (bus.s2p_ready) begin
              bus.x_we      <= 1'b1;
              bus.wr_addr   <= x_ptr;
              bus.wr_data_l <= bus.ParallelL;
              bus.wr_data_r <= bus.ParallelR;
              bus.alu_start <= 1'b1;
              bus.alu_xptr  <= x_ptr;
              x_ptr         <= x_ptr_next;
              zero_cnt      <= zc_next;
              bus.state     <= WORKING;
            end
          end

          WORKING: begin
            if (bus.s2p_ready && bus.alu_done) begin
              // Back-to-back frame: the ALU just freed up, so launch it again immediately.
              bus.x_we       <= 1'b1;
              bus.wr_addr    <= x_ptr;
              bus.wr_data_l  <= bus.ParallelL;
              bus.wr_data_r  <= bus.ParallelR;
              bus.alu_start  <= 1'b1;
              bus.alu_xptr   <= x_ptr;
              x_ptr          <= x_ptr_next;
              zero_cnt       <= zc_next;
              bus.state      <= (zc_next == ZC_MAX) ? SLEEP : WORKING;
              bus.sleep_flag <= (zc_next == ZC_MAX);
            end else if (bus.s2p_ready) begin
              bus.overrun <= 1'b1;
            end else if (bus.alu_done) begin
              bus.state      <= (zero_cnt == ZC_MAX) ? SLEEP : WAIT_INPUT;
              bus.sleep_flag <= (zero_cnt == ZC_MAX);
            end
          end

          SLEEP: begin
            if (bus.s2p_ready) begin
              // Samples keep landing in X so history is intact when real input returns.
              bus.x_we      <= 1'b1;
              bus.wr_addr   <= x_ptr;
              bus.wr_data_l <= bus.ParallelL;
              bus.wr_data_r <= bus.ParallelR;
              x_ptr         <= x_ptr_next;
              zero_cnt      <= zc_next;
              if (!frame_zero) begin
                bus.alu_start  <= 1'b1;
                bus.alu_xptr   <= x_ptr;
                bus.state      <= WORKING;
                bus.sleep_flag <= 1'b0;
              end
            end
          end

          default: begin
            bus.state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msdap_ctrl.sv
// Directed + randomized bench for msdap_ctrl with a frame-level reference model.
// Inputs are driven on the falling edge; outputs are sampled on the following falling edge.
// The model tracks mode, write pointer, zero run and overrun from the sequencer's rules.
module tb_msdap_ctrl;
  localparam int AW = 9;
  localparam int XD = 256;
  localparam int SZ = 800;

  logic SCLK;
  logic clear;
  int   n_chk;
  int   n_fail;

  // reference model state
  int mst;
  int xp;
  int zc;
  bit ovr;

  msdap_ctrl_if #(.ADDR_W(AW)) bus ();

  msdap_ctrl #(
    .RJ_COUNT(16), .COEFF_COUNT(512), .X_DEPTH(XD), .SLEEP_ZEROS(SZ), .ADDR_W(AW)
  ) dut (
    .SCLK(SCLK),
    .clear(clear),
    .bus(bus)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One input cycle: drive at the current falling edge, return at the next with inputs idle.
  task automatic step(input bit rdy, input bit done, input bit fl, input bit st,
                      input logic [15:0] l, input logic [15:0] r);
    bus.s2p_ready = rdy;
    bus.alu_done  = done;
    bus.flush     = fl;
    bus.start     = st;
    bus.ParallelL = l;
    bus.ParallelR = r;
    @(negedge SCLK);
    bus.s2p_ready = 1'b0;
    bus.alu_done  = 1'b0;
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.ParallelL = 16'd0;
    bus.ParallelR = 16'd0;
  endtask

  // Send one sample frame (optionally with a coincident alu_done) and check against the model.
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input bit with_done);
    bit acc;
    bit alu_exp;
    bit was_working;
    int waddr;
    acc = 0; alu_exp = 0; waddr = xp;
    was_working = (mst == 5);
    case (mst)
      4: begin acc = 1; alu_exp = 1; mst = 5; end
      5: begin
        if (with_done) begin acc = 1; alu_exp = 1; end
        else ovr = 1;
      end
      6: begin
        acc = 1;
        if (l != 0 || r != 0) begin alu_exp = 1; mst = 5; end
      end
      default: ;
    endcase
    if (acc) begin
      if (l == 0 && r == 0) begin
        if (zc < SZ) zc++;
      end else begin
        zc = 0;
      end
      xp = (xp + 1) % XD;
      if (was_working && with_done && zc == SZ) mst = 6;
    end
    step(1, with_done, 0, 0, l, r);
    chk("frame_x_we", bus.x_we, acc);
    if (acc) begin
      chk("frame_addr", bus.wr_addr, waddr);
      chk("frame_dat", {bus.wr_data_l, bus.wr_data_r}, {l, r});
    end
    chk("frame_alu_start", bus.alu_start, alu_exp);
    if (alu_exp) chk("frame_alu_xptr", bus.alu_xptr, waddr);
    chk("frame_state", bus.state, mst);
    chk("frame_overrun", bus.overrun, ovr);
    chk("frame_sleep", bus.sleep_flag, mst == 6);
  endtask

  task automatic done_only();
    if (mst == 5) mst = (zc == SZ) ? 6 : 4;
    step(0, 1, 0, 0, 16'd0, 16'd0);
    chk("done_state", bus.state, mst);
    chk("done_sleep", bus.sleep_flag, mst == 6);
    chk("done_alu_start", bus.alu_start, 0);
  endtask

  // Expect X_DEPTH consecutive zero writes, the first already visible; finish in state ret.
  task automatic expect_clear(input int ret);
    for (int k = 0; k < XD; k++) begin
      if (k != 0) @(negedge SCLK);
      chk("clr_we_addr", {bus.x_we, bus.wr_addr}, {1'b1, 9'(k)});
      chk("clr_dat", {bus.wr_data_l, bus.wr_data_r}, 32'd0);
    end
    chk("clr_done_state", bus.state, ret);
  endtask

  initial begin
    logic [15:0] l, r;
    n_chk = 0; n_fail = 0;
    mst = 0; xp = 0; zc = 0; ovr = 0;
    bus.start = 0; bus.flush = 0; bus.s2p_ready = 0; bus.alu_done = 0;
    bus.ParallelL = 0; bus.ParallelR = 0;
    clear = 1'b0;
    repeat (3) @(negedge SCLK);
    chk("rst_state", bus.state, 0);
    chk("rst_strobes", {bus.rj_we, bus.coeff_we, bus.x_we, bus.alu_start}, 0);
    chk("rst_flags", {bus.sleep_flag, bus.overrun}, 0);
    chk("rst_bus", {bus.wr_addr, bus.alu_xptr, bus.wr_data_l}, 0);
    clear = 1'b1;
    @(negedge SCLK);

    // IDLE ignores frames and flush
    step(1, 0, 1, 0, 16'h1111, 16'h2222);
    chk("idle_ignore", {bus.state, bus.rj_we, bus.coeff_we, bus.x_we}, 0);

    // power-up clear then Rj load
    step(0, 0, 0, 1, 16'd0, 16'd0);
    chk("clr_state", bus.state, 1);
    expect_clear(2);
    mst = 2;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge SCLK);
      if (i == 5) begin
        step(0, 0, 1, 1, 16'd0, 16'd0);
        chk("rj_flush_start_ignored", bus.state, 2);
      end
      l = 16'h0001 + 16'(i);
      r = 16'h8000 + 16'(i);
      step(1, 0, 0, 0, l, r);
      chk("rj_we_addr", {bus.rj_we, bus.coeff_we, bus.x_we, bus.wr_addr}, {3'b100, 9'(i)});
      chk("rj_dat", {bus.wr_data_l, bus.wr_data_r}, {l, r});
    end
    chk("rj_done_state", bus.state, 3);

    // coefficient load with random words
    for (int i = 0; i < 512; i++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      step(1, 0, 0, 0, l, r);
      chk("cf_we_addr", {bus.rj_we, bus.coeff_we, bus.x_we, bus.wr_addr}, {3'b010, 9'(i)});
      chk("cf_dat", {bus.wr_data_l, bus.wr_data_r}, {l, r});
    end
    chk("cf_done_state", bus.state, 4);
    mst = 4;

    // first sample frame
    frame(16'h1234, 16'hABCD, 0);
    chk("first_xptr", bus.alu_xptr, 0);
    done_only();
    step(0, 0, 0, 1, 16'd0, 16'd0);
    chk("wait_start_ignored", {bus.state, bus.x_we}, {3'd4, 1'b0});

    // wrap-around: 257 frames with prompt alu_done
    for (int i = 0; i < 257; i++) begin
      frame(16'($urandom_range(1, 65535)), 16'($urandom), 0);
      repeat ($urandom_range(0, 1)) @(negedge SCLK);
      done_only();
    end
    chk("wrap_ptr_model", bus.alu_xptr, (xp + XD - 1) % XD);

    // overrun then back-to-back accept
    frame(16'h0F0F, 16'h0001, 0);
    frame(16'h2222, 16'h3333, 0);
    frame(16'h4444, 16'h5555, 1);
    done_only();
    chk("overrun_sticky", bus.overrun, 1);

    // sustained zero input into sleep
    for (int i = 0; i < SZ; i++) begin
      frame(16'd0, 16'd0, 0);
      done_only();
    end
    chk("sleep_state", bus.state, 6);
    frame(16'd0, 16'd0, 0);
    frame(16'h0005, 16'd0, 0);
    chk("wake_state", bus.state, 5);
    done_only();

    // flush in WORKING with coincident frame and alu_done
    frame(16'h7777, 16'h1111, 0);
    step(1, 1, 1, 0, 16'h9999, 16'h8888);
    chk("flush_no_alu", bus.alu_start, 0);
    chk("flush_state", bus.state, 1);
    xp = 0; zc = 0; mst = 4;
    expect_clear(4);
    frame(16'h00AA, 16'h00BB, 0);
    chk("post_flush_addr", bus.wr_addr, 0);

    // reset in the middle of a clear
    step(0, 0, 1, 0, 16'd0, 16'd0);
    repeat (10) @(negedge SCLK);
    #2 clear = 1'b0;
    #1;
    chk("midclr_state", bus.state, 0);
    chk("midclr_strobes", {bus.x_we, bus.alu_start, bus.sleep_flag, bus.overrun}, 0);
    chk("midclr_bus", {bus.wr_addr, bus.alu_xptr, bus.wr_data_l, bus.wr_data_r}, 0);
    @(negedge SCLK);
    clear = 1'b1;
    @(negedge SCLK);
    chk("post_rst_idle", {bus.state, bus.x_we}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
